// File: rtl/demux_pkg.sv
// Shared definitions for the byte-lane mux/demux pair and the per-lane FIFOs.
package demux_pkg;

  localparam int DATA_W = 8;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // One lane slot as seen by the mux, demux and FIFOs.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } lane_word_t;

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry lane output register: hold under pause, release on consume, reload on write.
module demux_lane_reg #(
  parameter int W = demux_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         pause,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         can_accept
);

  // Free now, or the held word leaves on this edge.
  assign can_accept = !valid || !pause;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
    end else if (valid && !pause) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1a2_ochobits_cond.sv
// Byte-wide 1-to-2 demux: steers accepted words to lane 0/1 (alternating or external select).
module demux1a2_ochobits_cond #(
  parameter int DATA_W  = demux_pkg::DATA_W,
  parameter int SEL_EXT = 0
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              selector,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_in,
  input  logic              pause0,
  input  logic              pause1,
  output logic              validout0,
  output logic [DATA_W-1:0] dataout0,
  output logic              validout1,
  output logic [DATA_W-1:0] dataout1,
  output logic              drop_err
);

  logic sel_q;
  logic target;
  logic can_accept0;
  logic can_accept1;
  logic accept;
  logic wr_en0;
  logic wr_en1;

  assign target   = (SEL_EXT != 0) ? selector : sel_q;
  assign ready_in = reset_L && ((target == demux_pkg::LANE1) ? can_accept1 : can_accept0);
  assign accept   = valid_in && ready_in;
  assign wr_en0   = accept && (target == demux_pkg::LANE0);
  assign wr_en1   = accept && (target == demux_pkg::LANE1);

  // The alternating selector only advances on words that were actually taken.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel_q <= demux_pkg::LANE0;
    end else if (accept && (SEL_EXT == 0)) begin
      sel_q <= !sel_q;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      drop_err <= 1'b0;
    end else if (valid_in && !ready_in) begin
      drop_err <= 1'b1;
    end
  end

  demux_lane_reg #(.W(DATA_W)) u_lane0 (
    .clk        (clk),
    .reset_L    (reset_L),
    .wr_en      (wr_en0),
    .wr_data    (data_in),
    .pause      (pause0),
    .valid      (validout0),
    .data       (dataout0),
    .can_accept (can_accept0)
  );

  demux_lane_reg #(.W(DATA_W)) u_lane1 (
    .clk        (clk),
    .reset_L    (reset_L),
    .wr_en      (wr_en1),
    .wr_data    (data_in),
    .pause      (pause1),
    .valid      (validout1),
    .data       (dataout1),
    .can_accept (can_accept1)
  );

endmodule

// File: tb/tb_demux1a2_ochobits_cond.sv
// Scoreboard bench: alternating-select and external-select instances share the stimulus.
module tb_demux1a2_ochobits_cond;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       selector;
  logic       va, ve;
  logic [7:0] data_in;
  logic       pause0, pause1;

  logic       ra, vo0a, vo1a, dea;
  logic [7:0] do0a, do1a;
  logic       re, vo0e, vo1e, dee;
  logic [7:0] do0e, do1e;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] qa0[$], qa1[$], qe0[$], qe1[$];
  logic msel;
  logic drop_a, drop_e;
  bit   use_ext;

  always #5 clk = ~clk;

  demux1a2_ochobits_cond #(.DATA_W(8), .SEL_EXT(0)) dut_alt (
    .clk(clk), .reset_L(reset_L), .selector(selector), .valid_in(va), .data_in(data_in),
    .ready_in(ra), .pause0(pause0), .pause1(pause1), .validout0(vo0a), .dataout0(do0a),
    .validout1(vo1a), .dataout1(do1a), .drop_err(dea)
  );

  demux1a2_ochobits_cond #(.DATA_W(8), .SEL_EXT(1)) dut_ext (
    .clk(clk), .reset_L(reset_L), .selector(selector), .valid_in(ve), .data_in(data_in),
    .ready_in(re), .pause0(pause0), .pause1(pause1), .validout0(vo0e), .dataout0(do0e),
    .validout1(vo1e), .dataout1(do1e), .drop_err(dee)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The lane register must show exactly the oldest outstanding expected word.
  task automatic check_lane(input string tag, input logic v, input logic [7:0] d, input logic p,
                            input int qsize, input logic [7:0] front, output bit pop);
    check_eq({tag, "_valid"}, {31'd0, v}, {31'd0, qsize != 0});
    if (v && qsize != 0) check_eq({tag, "_data"}, {24'd0, d}, {24'd0, front});
    pop = v && !p && (qsize != 0);
  endtask

  task automatic flush_model();
    qa0.delete(); qa1.delete(); qe0.delete(); qe1.delete();
    msel   = 1'b0;
    drop_a = 1'b0;
    drop_e = 1'b0;
  endtask

  task automatic tick(input bit v, input logic [7:0] d, input logic sel,
                      input logic p0, input logic p1, input logic exp_rdy);
    bit pop;
    @(posedge clk); #1;
    if (use_ext) begin ve = v; va = 1'b0; end
    else         begin va = v; ve = 1'b0; end
    data_in = d; selector = sel; pause0 = p0; pause1 = p1;
    @(negedge clk);
    check_lane("alt_l0", vo0a, do0a, pause0, qa0.size(), (qa0.size() != 0) ? qa0[0] : 8'h00, pop);
    if (pop) void'(qa0.pop_front());
    check_lane("alt_l1", vo1a, do1a, pause1, qa1.size(), (qa1.size() != 0) ? qa1[0] : 8'h00, pop);
    if (pop) void'(qa1.pop_front());
    check_lane("ext_l0", vo0e, do0e, pause0, qe0.size(), (qe0.size() != 0) ? qe0[0] : 8'h00, pop);
    if (pop) void'(qe0.pop_front());
    check_lane("ext_l1", vo1e, do1e, pause1, qe1.size(), (qe1.size() != 0) ? qe1[0] : 8'h00, pop);
    if (pop) void'(qe1.pop_front());
    check_eq("alt_drop_err", {31'd0, dea}, {31'd0, drop_a});
    check_eq("ext_drop_err", {31'd0, dee}, {31'd0, drop_e});
    if (use_ext) check_eq("ext_ready", {31'd0, re}, {31'd0, exp_rdy});
    else         check_eq("alt_ready", {31'd0, ra}, {31'd0, exp_rdy});
    if (v) begin
      if (!exp_rdy) begin
        if (use_ext) drop_e = 1'b1; else drop_a = 1'b1;
      end else if (use_ext) begin
        if (sel) qe1.push_back(d); else qe0.push_back(d);
      end else begin
        if (msel) qa1.push_back(d); else qa0.push_back(d);
        msel = !msel;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_L = 1'b0; va = 1'b0; ve = 1'b0;
    flush_model();
    @(posedge clk); #1;
    reset_L = 1'b1;
  endtask

  initial begin
    use_ext  = 1'b0;
    flush_model();
    reset_L  = 1'b0;
    selector = 1'b0;
    pause0   = 1'b0;
    pause1   = 1'b0;
    va       = 1'b1;
    ve       = 1'b1;
    data_in  = 8'hAA;

    // Reset holds everything clear even with a word presented.
    @(negedge clk); @(negedge clk);
    check_eq("rst_alt_ready", {31'd0, ra}, 32'd0);
    check_eq("rst_ext_ready", {31'd0, re}, 32'd0);
    check_eq("rst_alt_v0", {31'd0, vo0a}, 32'd0);
    check_eq("rst_alt_v1", {31'd0, vo1a}, 32'd0);
    check_eq("rst_alt_d0", {24'd0, do0a}, 32'd0);
    check_eq("rst_alt_d1", {24'd0, do1a}, 32'd0);
    check_eq("rst_alt_drop", {31'd0, dea}, 32'd0);
    check_eq("rst_ext_v0", {31'd0, vo0e}, 32'd0);
    check_eq("rst_ext_v1", {31'd0, vo1e}, 32'd0);
    check_eq("rst_ext_drop", {31'd0, dee}, 32'd0);
    @(posedge clk); #1;
    reset_L = 1'b1; va = 1'b0; ve = 1'b0;

    tick(1, 8'h11, 0, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 0, 1);

    // Alternation with an idle cycle in the middle.
    apply_reset();
    tick(1, 8'h01, 0, 0, 0, 1);
    tick(1, 8'h02, 0, 0, 0, 1);
    tick(0, 8'hEE, 0, 0, 0, 1);
    tick(1, 8'h03, 0, 0, 0, 1);
    tick(1, 8'h04, 0, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 0, 1);

    // Backpressure on lane 0, then a dropped word, then release.
    tick(1, 8'h10, 0, 1, 0, 1);
    tick(1, 8'h20, 0, 1, 0, 1);
    tick(0, 8'h00, 0, 1, 0, 0);
    tick(1, 8'h5A, 0, 1, 0, 0);
    tick(1, 8'h30, 0, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 0, 1);
    tick(1, 8'h40, 0, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 0, 1);

    // Asynchronous reset while both lanes are full and paused.
    apply_reset();
    tick(1, 8'h61, 0, 1, 1, 1);
    tick(1, 8'h62, 0, 1, 1, 1);
    tick(0, 8'h00, 0, 1, 1, 0);
    #2 reset_L = 1'b0;
    #1;
    check_eq("async_rst_v0", {31'd0, vo0a}, 32'd0);
    check_eq("async_rst_v1", {31'd0, vo1a}, 32'd0);
    check_eq("async_rst_drop", {31'd0, dea}, 32'd0);
    flush_model();
    @(posedge clk); #1;
    reset_L = 1'b1;
    tick(1, 8'h71, 0, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 0, 1);

    // External selector instance.
    use_ext = 1'b1;
    tick(1, 8'hA1, 1, 0, 0, 1);
    tick(1, 8'hA2, 1, 0, 0, 1);
    tick(1, 8'hA3, 0, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 0, 1);
    tick(1, 8'hB1, 0, 1, 0, 1);
    tick(1, 8'hB2, 0, 1, 0, 0);
    tick(1, 8'hB3, 1, 1, 0, 1);
    tick(0, 8'h00, 0, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
